sdp_ram_ctrl: RTL
=================

Name: sdp_ram_ctrl

Overview:
Parametrised single-clock simple dual-port RAM for the FIFO storage path. It is the next generation of the team's dual-port RAM and adds:
- byte-lane write enables
- gated reads with a valid strobe and selectable 1- or 2-cycle read latency
- optional write-first collision bypass
- a hardware clear sequencer that zeroes the array one word per cycle
It sits between the FIFO pointer logic and the storage array.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8
ADDR_WIDTH, 4, address width
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
BYPASS, 1, 1 = write-first on same-address collision, 0 = read-old
CLR_ON_RST, 1, 1 = clear sequence starts automatically after reset release

Ports:
w_clk  input  1  clock, all logic on rising edge
w_rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_be  input  DATA_WIDTH/8  byte-lane enables; bit i covers wr_data[8i+7:8i]
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  read data, registered
rd_valid  output  1  one-cycle pulse per accepted read
clr_start  input  1  request a full-array clear
clr_busy  output  1  clear in progress; all requests ignored

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, read pipeline flushed, clr_ptr=0, FSM=IDLE. clr_busy=0 while w_rst is high. Array contents are not reset by w_rst.
- Reset asserted mid-clear aborts the sweep immediately; partially cleared contents are left as-is.
- FSM states: IDLE, CLEAR.
  - First edge after w_rst release: if CLR_ON_RST=1, go to CLEAR with clr_ptr=0; otherwise stay in IDLE.
  - IDLE: clr_start=1 -> CLEAR, clr_ptr=0.
  - CLEAR: each edge writes MEM[clr_ptr]=0 and increments clr_ptr. The edge that writes clr_ptr=DEPTH-1 returns to IDLE, so a clear takes exactly DEPTH cycles.
  - clr_busy = (state==CLEAR), registered.
  - clr_start while in CLEAR is ignored and does not restart the sweep.
- While clr_busy=1:
  - wr_en is dropped and no array write occurs.
  - rd_en is dropped and no rd_valid is generated.
  - Reads already in the pipeline before CLEAR was entered still complete.
- Write: on an edge with wr_en=1, clr_busy=0 and wr_addr<DEPTH, each lane i with wr_be[i]=1 updates MEM[wr_addr] lane i. Lanes with wr_be[i]=0 keep their value. wr_be=0 is a legal no-op.
- Write with wr_addr>=DEPTH is silently dropped.
- Read: a request is accepted on edge N when rd_en=1 and clr_busy=0.
  - RD_LATENCY=1: rd_data and rd_valid update at edge N and are visible during cycle N+1.
  - RD_LATENCY=2: an extra output register stage; visible during cycle N+2.
  - Back-to-back reads are accepted every cycle at full throughput.
  - rd_valid is high for exactly one cycle per accepted read.
  - rd_data holds its last value when no read completes.
- Read with rd_addr>=DEPTH returns 0 with rd_valid=1.
- Collision (accepted read and write to the same address on the same edge):
  - BYPASS=1: returned word = new bytes on enabled lanes, old bytes on the others.
  - BYPASS=0: returned word = old contents.
  - The write always completes.
- A read issued on the cycle immediately after clr_busy falls sees zeros for every cleared word.
- Assertions in simulation:
  - RD_LATENCY not in {1,2} -> $error.
  - DATA_WIDTH%8 != 0 -> $error.
  - DEPTH > 2**ADDR_WIDTH -> $error.

Test Plan:
- Reset, CLR_ON_RST=1, DEPTH=12 -> clr_busy high for exactly 12 cycles starting the edge after w_rst release. Then read addr 0..11 -> rd_valid pulses, all rd_data=0x00000000.
- Write 0xA5A5A5A5 with be=1111 to addr 3, then 0x11223344 with be=0101 to addr 3. Read addr 3 with RD_LATENCY=1 -> rd_data=0xA522A544 one cycle after the accepted read; with RD_LATENCY=2 -> same value two cycles after.
- Same-cycle write 0xDEADBEEF (be=1100) and read, both to addr 5, which holds 0x01020304 -> BYPASS=1 returns 0xDEAD0304; BYPASS=0 returns 0x01020304. Addr 5 holds 0xDEAD0304 afterwards in both cases.
- Write 0xFFFFFFFF to addr 13 with DEPTH=12 -> no array change. Read addr 13 -> rd_valid=1, rd_data=0.
- Pulse clr_start with non-zero data resident; during clear drive wr_en to addr 2 and rd_en -> write dropped, no rd_valid. A second clr_start mid-sweep -> sweep length unchanged. After clear, addr 2 reads 0.
- Assert w_rst at sweep cycle 4 of 12 -> clr_busy=0, rd_valid=0, rd_data=0 immediately. On release with CLR_ON_RST=1 -> a fresh 12-cycle sweep completes.

Source files
------------

// File: rtl/sdp_ram_ctrl_if.sv
// rtl/sdp_ram_ctrl_if.sv - write/read/clear port bundle for sdp_ram_ctrl
interface sdp_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) ();
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_be;
    logic                      rd_en;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_valid;
    logic                      clr_start;
    logic                      clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_start,
        input  rd_data, rd_valid, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_start,
        output rd_data, rd_valid, clr_busy
    );
endinterface

// File: rtl/sdp_ram_ctrl.sv
// rtl/sdp_ram_ctrl.sv - simple dual-port RAM with byte enables, gated reads and clear sequencer
module sdp_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic           w_clk,
    input  logic           w_rst,
    sdp_ram_ctrl_if.slave  bus
);
    localparam int                    NLANES   = DATA_WIDTH / 8;
    localparam logic [31:0]           DEPTH_W  = DEPTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_ctrl: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sdp_ram_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("sdp_ram_ctrl: DEPTH exceeds address space");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic                    init_q;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    busy;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    rd_in_range;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_data1_q;
    logic                    rd_valid1_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign busy         = (state_q == CLEAR);
    assign bus.clr_busy = busy;
    assign wr_ok        = bus.wr_en && !busy && (32'(bus.wr_addr) < DEPTH_W);
    assign rd_ok        = bus.rd_en && !busy;
    assign rd_in_range  = (32'(bus.rd_addr) < DEPTH_W);

    // init_q marks the first edge after reset release for the auto-clear
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            init_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            init_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if ((init_q && (CLR_ON_RST != 0)) || bus.clr_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is never reset; only the sweep or a lane write changes it
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            if (busy) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (bus.wr_be[i]) begin
                        mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
        end
        if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < NLANES; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rd_data1_q  <= '0;
            rd_valid1_q <= 1'b0;
        end else begin
            rd_valid1_q <= rd_ok;
            if (rd_ok) begin
                rd_data1_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rd_data2_q;
        logic                  rd_valid2_q;

        always_ff @(posedge w_clk or posedge w_rst) begin
            if (w_rst) begin
                rd_data2_q  <= '0;
                rd_valid2_q <= 1'b0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
                if (rd_valid1_q) begin
                    rd_data2_q <= rd_data1_q;
                end
            end
        end

        assign bus.rd_data  = rd_data2_q;
        assign bus.rd_valid = rd_valid2_q;
    end else begin : g_lat1
        assign bus.rd_data  = rd_data1_q;
        assign bus.rd_valid = rd_valid1_q;
    end
endmodule
